// File: rtl/divider_unit_pkg.sv
// -----------------------------------------------------------------------------
// divider_unit_pkg
// Shared definitions for the iterative RV32M divider:
//   - op encodings DIV/DIVU/REM/REMU
//   - FSM state encodings IDLE/CALC/DONE
//   - DIV_ITER iteration count
//   - helpers for operand magnitude and the RISC-V special-case results
// -----------------------------------------------------------------------------
package divider_unit_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    // Two's-complement negate when neg is set; 0x80000000 maps onto itself,
    // which is the correct unsigned magnitude of INT_MIN.
    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = ~x + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Result of the two RISC-V special cases (divide by zero, signed
    // overflow). Sign fix-up never applies to these.
    function automatic logic [31:0] special_res(input logic [1:0] op,
                                                input logic       div0,
                                                input logic [31:0] dividend);
        logic [31:0] r;
        if (div0) begin
            r = op[1] ? dividend : 32'hFFFF_FFFF;
        end else begin
            r = op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
        return r;
    endfunction

endpackage

// File: rtl/divider_unit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract iteration.
//   acc_in  [63:0] : {rem, quo} before the iteration
//   dvsr    [31:0] : divisor magnitude
//   acc_out [63:0] : {rem, quo} after the iteration
// -----------------------------------------------------------------------------
module div_step (
    input  logic [63:0] acc_in,
    input  logic [31:0] dvsr,
    output logic [63:0] acc_out
);

    logic [32:0] rem_sh_s;
    logic [32:0] trial_s;
    logic        trial_ok_s;

    // Shift {rem,quo} left, trial-subtract the divisor from the upper 33 bits.
    // The partial remainder is always below the divisor, so a 33-bit
    // subtract is wide enough for its top bit to be the sign.
    always_comb begin
        rem_sh_s   = acc_in[63:31];
        trial_s    = rem_sh_s - {1'b0, dvsr};
        trial_ok_s = ~trial_s[32];
        if (trial_ok_s) begin
            acc_out = {trial_s[31:0], acc_in[30:0], 1'b1};
        end else begin
            acc_out = {rem_sh_s[31:0], acc_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_unit.sv
// -----------------------------------------------------------------------------
// divider_unit
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per
// cycle. Accepted start -> 32 CALC cycles -> one DONE cycle with done pulse.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   start    : request, sampled only in IDLE
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend : rs1, captured on accepted start
//   divisor  : rs2, captured on accepted start
//   flush    : abort any operation, back to IDLE without done
//   busy     : high in CALC and DONE (registered)
//   done     : one-cycle pulse, result valid (registered)
//   result   : quotient/remainder, held until the next completion
// Build option: DIVIDER_FASTPATH_EN -- divide-by-zero and signed overflow go
// straight from IDLE to DONE instead of running the 32 iterations.
// -----------------------------------------------------------------------------
module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_t  state_r;
    div_state_t  next_state_s;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;
    logic [63:0] acc_nxt_s;
    logic [31:0] dvsr_r;
    logic [31:0] dvd_orig_r;
    logic [1:0]  op_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        div0_r;
    logic        ovf_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        busy_d_s;
    logic        done_d_s;

    logic        dvd_neg_s;
    logic        dvs_neg_s;
    logic        div0_s;
    logic        ovf_s;
    logic        accept_s;
    logic        last_iter_s;
    logic [31:0] res_calc_s;

    div_step u_step (
        .acc_in  (acc_r),
        .dvsr    (dvsr_r),
        .acc_out (acc_nxt_s)
    );

    // Operand classification and request acceptance.
    always_comb begin
        dvd_neg_s   = ~op[0] & dividend[31];
        dvs_neg_s   = ~op[0] & divisor[31];
        div0_s      = (divisor == 32'h0000_0000);
        ovf_s       = ~op[0] & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
        accept_s    = (state_r == ST_IDLE) & start & ~flush;
        last_iter_s = (state_r == ST_CALC) & (cnt_r == 5'd0);
    end

    // Final special-case mux and sign fix-up applied to the last iteration.
    always_comb begin
        if (div0_r || ovf_r) begin
            res_calc_s = special_res(op_r, div0_r, dvd_orig_r);
        end else if (op_r[1]) begin
            res_calc_s = cond_neg(acc_nxt_s[63:32], neg_r_r & (op_r == OP_REM));
        end else begin
            res_calc_s = cond_neg(acc_nxt_s[31:0], neg_q_r & (op_r == OP_DIV));
        end
    end

    // FSM state register plus registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= busy_d_s;
            done_r  <= done_d_s;
        end
    end

    // FSM next-state logic; flush has priority over everything.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    next_state_s = ST_IDLE;
                end else if (start) begin
`ifdef DIVIDER_FASTPATH_EN
                    if (div0_s || ovf_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CALC;
                    end
`else
                    next_state_s = ST_CALC;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == 5'd0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the next state so busy/done come out of flops.
    always_comb begin
        busy_d_s = (next_state_s != ST_IDLE);
        done_d_s = (next_state_s == ST_DONE);
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r      <= 5'd0;
            acc_r      <= 64'd0;
            dvsr_r     <= 32'd0;
            dvd_orig_r <= 32'd0;
            op_r       <= 2'b00;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div0_r     <= 1'b0;
            ovf_r      <= 1'b0;
            result_r   <= 32'd0;
        end else if (accept_s) begin
            cnt_r      <= 5'(DIV_ITER - 1);
            acc_r      <= {32'd0, cond_neg(dividend, dvd_neg_s)};
            dvsr_r     <= cond_neg(divisor, dvs_neg_s);
            dvd_orig_r <= dividend;
            op_r       <= op;
            neg_q_r    <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r    <= dvd_neg_s;
            div0_r     <= div0_s;
            ovf_r      <= ovf_s;
`ifdef DIVIDER_FASTPATH_EN
            if (div0_s || ovf_s) begin
                result_r <= special_res(op, div0_s, dividend);
            end
`endif
        end else if ((state_r == ST_CALC) && !flush) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r - 5'd1;
            if (last_iter_s) begin
                result_r <= res_calc_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_divider_unit.sv
// -----------------------------------------------------------------------------
// tb_divider_unit
// Self-checking bench for divider_unit: directed RV32M cases, randomized
// operations against a plain-arithmetic reference, flush, ignored start,
// mid-operation reset and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_exp = 32'd0;

    divider_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0] == 1'b0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = o[1] ? (sa % sb) : (sa / sb);
        return q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIVIDER_FASTPATH_EN
        return special ? 1 : 33;
`else
        if (special) return 33;
        return 33;
`endif
    endfunction

    // Issue one op at the current (post-negedge) point, follow it to completion,
    // and leave the bench in the cycle after DONE, where a new start may go.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp, got;
        int lat, elat;
        bit busy_bad;
        exp  = ref_div(o, a, b);
        elat = ref_lat(o, a, b);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_bad = 1'b0; got = 32'd0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                lat = k;
                got = result;
            end else begin
                @(negedge clk);
            end
        end
        n_cmp++;
        if (lat == 0) begin
            n_err++;
            $display("FAIL %s timeout: done not seen within 40 cycles, required cycle %0d", name, elat);
        end else begin
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s result: got %h required %h (op=%b a=%h b=%h)", name, got, exp, o, a, b);
            end
            if (lat != elat) begin
                n_err++;
                $display("FAIL %s latency: done in cycle %0d required %0d", name, lat, elat);
            end
            n_cmp++;
            if (busy_bad) begin
                n_err++;
                $display("FAIL %s busy: busy dropped during cycles 1..%0d, required 1", name, lat);
            end
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== exp) begin
                n_err++;
                $display("FAIL %s after: busy=%b done=%b result=%h required 0 0 %h", name, busy, done, result, exp);
            end
        end
        last_exp = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        last_exp = 32'd0;
    endtask

    task automatic test_directed();
        run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(2'b00, 32'd5, 32'd0, "div_5_0");
        run_op(2'b11, 32'd5, 32'd0, "remu_5_0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "rem_m7_0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "remu_same");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = -32'($urandom_range(1, 15));
                2: b = (i % 6 == 0) ? 32'd0 : $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(o, a, b, "random");
        end
    endtask

    // Back-to-back: the second request is raised in the very cycle after DONE.
    task automatic test_back_to_back();
        run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, "b2b_first");
        run_op(2'b11, 32'd1000, 32'd7, "b2b_second");
    endtask

    task automatic test_flush();
        bit seen;
        // flush in cycle 10 of a CALC run
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_calc: busy=%b done=%b in cycle 11 required 0 0", busy, done);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen || result !== last_exp) begin
            n_err++;
            $display("FAIL flush_quiet: activity=%b result=%h required 0 %h", seen, result, last_exp);
        end
        // flush and start together in IDLE: nothing accepted
        op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen || result !== last_exp) begin
            n_err++;
            $display("FAIL flush_start_idle: activity=%b result=%h required 0 %h", seen, result, last_exp);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        op = 2'b00; dividend = 32'd1; divisor = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 21; k <= 45 && lat == 0; k++) begin
            if (done === 1'b1) lat = k;
            else @(negedge clk);
        end
        n_cmp++;
        if (lat != 33 || result !== 32'd14) begin
            n_err++;
            $display("FAIL ignored_start: done cycle %0d result %h required 33 0000000e", lat, result);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_start_idle: busy=%b required 0", busy);
        end
        last_exp = 32'd14;
    endtask

    task automatic test_reset_mid();
        op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
        end
        rst_n = 1'b1;
        last_exp = 32'd0;
        @(negedge clk);
        run_op(2'b01, 32'd9, 32'd3, "divu_9_3");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_ignored_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
